// File: rtl/gcm_block_sequencer.sv
// rtl/gcm_block_sequencer.sv - AES-GCM front-end feeder: sequences AAD, TEXT and LEN pipeline words.
// Block indices start at 0 for the first AAD block; the counter-block stage relies on that numbering.
module gcm_block_sequencer #(
    parameter int LEN_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [0:95]        i_iv,
    input  logic [0:LEN_W-1]   i_len_a,
    input  logic [0:LEN_W-1]   i_len_p,
    output logic               o_busy,
    input  logic               i_data_valid,
    input  logic [0:127]       i_data,
    output logic               o_data_ready,
    output logic               o_new_instance,
    output logic [0:2]         o_phase,
    output logic [0:127]       o_counter,
    output logic [0:127]       o_aad,
    output logic [0:127]       o_plain_text,
    output logic [0:95]        o_iv,
    output logic [0:2*LEN_W-1] o_instance_size
);

    typedef enum logic [1:0] {S_IDLE, S_AAD, S_TEXT, S_LEN} state_t;

    state_t             state_q, state_d;
    logic [95:0]        iv_q, iv_d;
    logic [LEN_W-1:0]   len_a_q, len_a_d, len_p_q, len_p_d;
    logic [LEN_W-1:0]   na_q, na_d, np_q, np_d, cnt_q, cnt_d;
    logic [31:0]        idx_q, idx_d, ctr_q, ctr_d;
    logic               armed_q, armed_d, busy_q, busy_d, new_q, new_d;
    logic [2:0]         phase_q, phase_d;
    logic [127:0]       aad_q, aad_d, pt_q, pt_d;

    logic [LEN_W-1:0]   len_a_in, len_p_in;
    logic [LEN_W:0]     np_sum;
    logic [6:0]         tail_bits;
    logic [127:0]       tail_mask;
    logic               last_blk;

    assign len_a_in  = i_len_a;
    assign len_p_in  = i_len_p;
    assign np_sum    = {1'b0, len_p_in} + (LEN_W+1)'(127);
    assign tail_bits = len_p_q[6:0];
    // Keeps the leading tail_bits bits (MSB-first) of the final plaintext block.
    assign tail_mask = ~({128{1'b1}} >> tail_bits);
    assign last_blk  = (state_q == S_AAD) ? (cnt_q == na_q - LEN_W'(1))
                                          : (cnt_q == np_q - LEN_W'(1));

    assign o_data_ready    = (state_q == S_AAD) || (state_q == S_TEXT);
    assign o_busy          = busy_q;
    assign o_new_instance  = new_q;
    assign o_phase         = phase_q;
    assign o_counter       = {96'b0, ctr_q};
    assign o_aad           = aad_q;
    assign o_plain_text    = pt_q;
    assign o_iv            = iv_q;
    assign o_instance_size = {len_a_q, len_p_q};

    always_comb begin
        state_d = state_q;
        iv_d    = iv_q;
        len_a_d = len_a_q;
        len_p_d = len_p_q;
        na_d    = na_q;
        np_d    = np_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        armed_d = armed_q;
        phase_d = 3'b111;
        aad_d   = '0;
        pt_d    = '0;
        new_d   = 1'b0;
        ctr_d   = (state_q == S_IDLE) ? 32'd0 : idx_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    iv_d    = i_iv;
                    len_a_d = len_a_in;
                    len_p_d = len_p_in;
                    na_d    = len_a_in >> 7;
                    np_d    = LEN_W'(np_sum >> 7);
                    cnt_d   = '0;
                    idx_d   = '0;
                    armed_d = 1'b1;
                    if ((len_a_in >> 7) != '0)           state_d = S_AAD;
                    else if (LEN_W'(np_sum >> 7) != '0)  state_d = S_TEXT;
                    else                                 state_d = S_LEN;
                end
            end
            S_AAD, S_TEXT: begin
                if (i_data_valid) begin
                    new_d   = armed_q;
                    armed_d = 1'b0;
                    idx_d   = idx_q + 32'd1;
                    if (state_q == S_AAD) begin
                        phase_d = 3'b001;
                        aad_d   = i_data;
                    end else begin
                        phase_d = 3'b010;
                        pt_d    = (last_blk && tail_bits != 7'd0) ? (i_data & tail_mask) : i_data;
                    end
                    if (last_blk) begin
                        cnt_d = '0;
                        if (state_q == S_AAD && np_q != '0) state_d = S_TEXT;
                        else                                 state_d = S_LEN;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            S_LEN: begin
                phase_d = 3'b100;
                aad_d   = 128'({len_a_q, len_p_q});
                new_d   = armed_q;
                armed_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            iv_q    <= '0;
            len_a_q <= '0;
            len_p_q <= '0;
            na_q    <= '0;
            np_q    <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            ctr_q   <= '0;
            armed_q <= 1'b0;
            busy_q  <= 1'b0;
            new_q   <= 1'b0;
            phase_q <= 3'b111;
            aad_q   <= '0;
            pt_q    <= '0;
        end else begin
            state_q <= state_d;
            iv_q    <= iv_d;
            len_a_q <= len_a_d;
            len_p_q <= len_p_d;
            na_q    <= na_d;
            np_q    <= np_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ctr_q   <= ctr_d;
            armed_q <= armed_d;
            busy_q  <= busy_d;
            new_q   <= new_d;
            phase_q <= phase_d;
            aad_q   <= aad_d;
            pt_q    <= pt_d;
        end
    end

endmodule
